// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad debounce/encoder block.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DEB_PRESS,
    PRESSED,
    DEB_RELEASE
  } kp_state_t;

  // Widest keypad the encode helper accepts; callers zero-extend into it.
  localparam int MAX_KEYS = 64;

  // Highest set index wins; only the low n_keys bits are considered.
  function automatic int prio_encode(input logic [MAX_KEYS-1:0] keys, input int n_keys);
    prio_encode = 0;
    for (int i = 0; i < MAX_KEYS; i++) begin
      if (i < n_keys && keys[i]) prio_encode = i;
    end
  endfunction

endpackage

// File: rtl/keypad_debounce_encoder_if.sv
// Keypad-side and consumer-side signals of the debounce encoder.
// slave: the encoder; master: the keypad driver / control FSM side.
interface keypad_if #(
  parameter int N_KEYS = 10
);
  localparam int CODE_W = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;

  logic [N_KEYS-1:0] keypad;
  logic              enablen;
  logic [CODE_W-1:0] code;
  logic              data_valid;
  logic              key_held;
  logic              multi_press;

  modport slave (
    input  keypad, enablen,
    output code, data_valid, key_held, multi_press
  );

  modport master (
    output keypad, enablen,
    input  code, data_valid, key_held, multi_press
  );
endinterface

// File: rtl/sync_2ff.sv
// N-bit two-flop synchroniser for asynchronous level inputs.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;

  // NOTE: non-blocking assignments keep meta->q a true two-stage shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/keypad_debounce_encoder.sv
// Synchronise, debounce and priority-encode an N-key keypad; one data_valid per press.
// Optional auto-repeat while held: define KEYPAD_AUTO_REPEAT_EN.
module keypad_debounce_encoder
  import keypad_pkg::*;
#(
  parameter int N_KEYS          = 10,
  parameter int DEBOUNCE_CYCLES = 16
`ifdef KEYPAD_AUTO_REPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 500,
  parameter int REPEAT_PERIOD   = 100
`endif
) (
  input  logic     clk,
  input  logic     rst,
  keypad_if.slave  kp
);
  localparam int CODE_W = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;
  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_KEYS-1:0] sample;
  logic              any;
  logic [CODE_W-1:0] enc;

  kp_state_t         state;
  logic [CNT_W-1:0]  cnt;
  logic [CODE_W-1:0] cand;
  logic [CODE_W-1:0] code;
  logic              data_valid;
  logic              key_held;
  logic              multi_press;

`ifdef KEYPAD_AUTO_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  logic [REP_W-1:0] rep_cnt;
  logic             rep_started;
`endif

  sync_2ff #(.WIDTH(N_KEYS)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (kp.keypad),
    .q   (sample)
  );

  assign any = |sample;
  assign enc = CODE_W'(prio_encode(MAX_KEYS'(sample), N_KEYS));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      cand        <= '0;
      code        <= '0;
      data_valid  <= 1'b0;
      key_held    <= 1'b0;
      multi_press <= 1'b0;
`ifdef KEYPAD_AUTO_REPEAT_EN
      rep_cnt     <= '0;
      rep_started <= 1'b0;
`endif
    end else begin
      multi_press <= ($countones(sample) > 1);
      data_valid  <= 1'b0;

      if (kp.enablen) begin
        // Disable aborts everything except the last accepted code.
        state    <= IDLE;
        cnt      <= '0;
        key_held <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
`ifdef KEYPAD_AUTO_REPEAT_EN
            rep_cnt     <= '0;
            rep_started <= 1'b0;
`endif
            if (any) begin
              state <= DEB_PRESS;
              cand  <= enc;
              cnt   <= '0;
            end
          end

          DEB_PRESS: begin
            if (!any || enc != cand) begin
              state <= IDLE;
            end else if (cnt == CNT_LAST) begin
              state      <= PRESSED;
              code       <= cand;
              data_valid <= 1'b1;
              key_held   <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          PRESSED: begin
            if (!any) begin
              state <= DEB_RELEASE;
              cnt   <= '0;
            end
`ifdef KEYPAD_AUTO_REPEAT_EN
            else if (rep_cnt == REP_W'((rep_started ? REPEAT_PERIOD : REPEAT_DELAY) - 1)) begin
              data_valid  <= 1'b1;
              rep_cnt     <= '0;
              rep_started <= 1'b1;
            end else begin
              rep_cnt <= rep_cnt + 1'b1;
            end
`endif
          end

          DEB_RELEASE: begin
            if (any) begin
              state <= PRESSED;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state    <= IDLE;
              key_held <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

  assign kp.code        = code;
  assign kp.data_valid  = data_valid;
  assign kp.key_held    = key_held;
  assign kp.multi_press = multi_press;

endmodule

// File: tb/tb_keypad_debounce_encoder.sv
// Self-checking bench: directed scenarios plus random stimulus against a run-length model.
module tb_keypad_debounce_encoder;
  localparam int NK  = 10;
  localparam int DEB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  keypad_if #(.N_KEYS(NK)) kif ();

  keypad_debounce_encoder #(.N_KEYS(NK), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kif.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;
  logic prev_dv = 1'b0;

  // Reference model: a press is accepted once DEB+1 consecutive samples carry the
  // same non-zero encoded key; release once DEB+1 consecutive all-zero samples are seen.
  logic [NK-1:0] m_s1 = '0, m_s2 = '0;
  bit m_held = 0, m_dv = 0, m_multi = 0;
  int m_run = 0, m_rcode = 0, m_code = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  function automatic int top_key(input logic [NK-1:0] s);
    for (int i = NK - 1; i >= 0; i--) if (s[i]) return i;
    return 0;
  endfunction

  function automatic int ones(input logic [NK-1:0] s);
    int c = 0;
    for (int i = 0; i < NK; i++) c += int'(s[i]);
    return c;
  endfunction

  task automatic model_step(input logic [NK-1:0] k, input logic en_n, input logic r);
    logic [NK-1:0] s;
    int e;
    if (r) begin
      m_s1 = '0; m_s2 = '0; m_held = 0; m_dv = 0; m_multi = 0;
      m_run = 0; m_rcode = 0; m_code = 0;
      return;
    end
    s = m_s2;
    e = top_key(s);
    m_dv = 0;
    m_multi = (ones(s) > 1);
    if (en_n) begin
      m_held = 0;
      m_run  = 0;
    end else if (!m_held) begin
      if (m_run == 0) begin
        if (s != 0) begin m_run = 1; m_rcode = e; end
      end else if (s != 0 && e == m_rcode) begin
        m_run++;
      end else begin
        m_run = 0;
      end
      if (m_run == DEB + 1) begin
        m_held = 1; m_code = m_rcode; m_dv = 1; m_run = 0;
      end
    end else begin
      if (s == 0) m_run++; else m_run = 0;
      if (m_run == DEB + 1) begin m_held = 0; m_run = 0; end
    end
    m_s2 = m_s1;
    m_s1 = k;
  endtask

  task automatic tick(input logic [NK-1:0] k, input logic en_n = 1'b0, input logic r = 1'b0);
    kif.keypad  = k;
    kif.enablen = en_n;
    rst         = r;
    @(posedge clk);
    model_step(k, en_n, r);
    #1;
    edge_n++;
    check("code", 32'(kif.code), 32'(m_code));
    check("data_valid", 32'(kif.data_valid), 32'(m_dv));
    check("key_held", 32'(kif.key_held), 32'(m_held));
    check("multi_press", 32'(kif.multi_press), 32'(m_multi));
    check("dv_back_to_back", 32'(kif.data_valid & prev_dv), 32'd0);
    prev_dv = kif.data_valid;
  endtask

  // Hold one pattern for n edges; returns strobe count and edge of first strobe.
  task automatic hold(input logic [NK-1:0] k, input int n, output int dv_cnt,
                      output int first_dv, input logic en_n = 1'b0);
    dv_cnt = 0;
    first_dv = -1;
    for (int i = 1; i <= n; i++) begin
      tick(k, en_n);
      if (kif.data_valid) begin
        dv_cnt++;
        if (first_dv < 0) first_dv = i;
      end
    end
  endtask

  initial begin
    int dvc, fdv, rel;
    logic [NK-1:0] pat;

    kif.keypad = '0; kif.enablen = 1'b0; rst = 1'b1;

    // Reset
    tick('0, 1'b0, 1'b1);
    tick('0, 1'b0, 1'b1);
    check("rst_code", 32'(kif.code), 32'd0);
    check("rst_dv", 32'(kif.data_valid), 32'd0);
    check("rst_held", 32'(kif.key_held), 32'd0);
    check("rst_multi", 32'(kif.multi_press), 32'd0);
    hold('0, 4, dvc, fdv);

    // Clean press of key 5 and its release
    hold(10'b0000100000, 12, dvc, fdv);
    check("press_edge", 32'(fdv), 32'd7);
    check("press_count", 32'(dvc), 32'd1);
    check("press_code", 32'(kif.code), 32'd5);
    check("press_held", 32'(kif.key_held), 32'd1);
    rel = 99;
    for (int i = 1; i <= 20; i++) begin
      tick('0);
      if (!kif.key_held) begin rel = i; break; end
    end
    check("release_edge", 32'(rel), 32'd7);
    hold('0, 4, dvc, fdv);

    // Bounce on key 3, then stable
    dvc = 0;
    for (int i = 0; i < 20; i++) begin
      tick(((i / 2) % 2 == 0) ? 10'b0000001000 : 10'b0);
      if (kif.data_valid) dvc++;
    end
    check("bounce_no_strobe", 32'(dvc), 32'd0);
    hold(10'b0000001000, 12, dvc, fdv);
    check("bounce_one_strobe", 32'(dvc), 32'd1);
    check("bounce_code", 32'(kif.code), 32'd3);
    hold('0, 10, dvc, fdv);

    // Keys 9 and 2 together
    hold(10'b1000000100, 10, dvc, fdv);
    check("multi_code", 32'(kif.code), 32'd9);
    check("multi_flag", 32'(kif.multi_press), 32'd1);
    check("multi_count", 32'(dvc), 32'd1);
    hold('0, 10, dvc, fdv);
    check("multi_clear", 32'(kif.multi_press), 32'd0);

    // enablen during debounce of key 1
    hold(10'b0000000010, 3, dvc, fdv);
    hold(10'b0000000010, 2, rel, fdv, 1'b1);
    dvc += rel;
    hold('0, 12, rel, fdv);
    dvc += rel;
    check("en_deb_no_strobe", 32'(dvc), 32'd0);
    check("en_deb_code_kept", 32'(kif.code), 32'd9);

    // enablen while key 4 is pressed
    hold(10'b0000010000, 10, dvc, fdv);
    check("en_pr_code", 32'(kif.code), 32'd4);
    tick(10'b0000010000, 1'b1);
    check("en_pr_held_low", 32'(kif.key_held), 32'd0);
    check("en_pr_code_kept", 32'(kif.code), 32'd4);
    hold('0, 10, dvc, fdv);

    // Release glitch on key 6
    hold(10'b0001000000, 10, dvc, fdv);
    check("glitch_first", 32'(dvc), 32'd1);
    rel = 1;
    dvc = 0;
    for (int i = 0; i < 12; i++) begin
      tick((i == 0 || i == 1) ? 10'b0 : 10'b0001000000);
      rel &= int'(kif.key_held);
      if (kif.data_valid) dvc++;
    end
    check("glitch_no_strobe", 32'(dvc), 32'd0);
    check("glitch_held", 32'(rel), 32'd1);
    hold('0, 10, dvc, fdv);

    // Random segments
    for (int seg = 0; seg < 300; seg++) begin
      case ($urandom_range(0, 9))
        0, 1, 2:    pat = '0;
        3, 4, 5, 6: pat = NK'(1) << $urandom_range(0, NK - 1);
        7, 8:       pat = (NK'(1) << $urandom_range(0, NK - 1)) | (NK'(1) << $urandom_range(0, NK - 1));
        default:    pat = NK'($urandom);
      endcase
      if ($urandom_range(0, 49) == 0) tick(pat, 1'b0, 1'b1);
      for (int i = $urandom_range(1, 12); i > 0; i--)
        tick(pat, ($urandom_range(0, 29) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
